// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared pattern constants and types for the seven-segment decoder.
// Segment order is bit 0 = a ... bit 6 = g, active-low (0 = segment lit).
// Imported by sevenseg_lut and sevenseg_decoder.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [0:0] {
    TRACK  = 1'b0,
    LOCKED = 1'b1
  } dec_state_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_lut.sv
// sevenseg_lut: combinational segment pattern -> {digit, is_legal, is_blank}.
// Ports: seg_i (active-low pattern), digit_o, is_legal_o, is_blank_o.
// Macro SEVENSEG_HEX_EN: when defined, A-F patterns decode as legal 4'hA-4'hF.
module sevenseg_lut
  import sevenseg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] digit_o,
  output logic       is_legal_o,
  output logic       is_blank_o
);

  always_comb begin
    digit_o    = 4'd0;
    is_legal_o = 1'b1;
    is_blank_o = 1'b0;
    unique case (seg_i)
      SEG_0: digit_o = 4'd0;
      SEG_1: digit_o = 4'd1;
      SEG_2: digit_o = 4'd2;
      SEG_3: digit_o = 4'd3;
      SEG_4: digit_o = 4'd4;
      SEG_5: digit_o = 4'd5;
      SEG_6: digit_o = 4'd6;
      SEG_7: digit_o = 4'd7;
      SEG_8: digit_o = 4'd8;
      SEG_9: digit_o = 4'd9;
`ifdef SEVENSEG_HEX_EN
      SEG_A: digit_o = 4'hA;
      SEG_B: digit_o = 4'hB;
      SEG_C: digit_o = 4'hC;
      SEG_D: digit_o = 4'hD;
      SEG_E: digit_o = 4'hE;
      SEG_F: digit_o = 4'hF;
`endif
      SEG_BLANK: begin
        // All-off is its own category: neither a digit nor an error.
        is_legal_o = 1'b0;
        is_blank_o = 1'b1;
      end
      default: is_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: recovers the digit shown on an active-low 7-segment bus once
// the pattern has been stable for STABLE_CYCLES consecutive samples.
// Ports: clk, reset (async, active-high), seg_in[6:0] -> digit[3:0], digit_valid
// (one-cycle lock pulse), blank/err (levels for the last locked pattern).
// Macro SEVENSEG_HEX_EN (inside sevenseg_lut) enables A-F as legal codes.
module sevenseg_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       err
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seg_t             seg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dec_state_t       state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;

  logic             new_run;
  logic             lock;
  logic [3:0]       lut_digit;
  logic             lut_legal;
  logic             lut_blank;

  // Decode the live input: on a lock edge the sample being accepted is seg_in.
  sevenseg_lut u_lut (
    .seg_i      (seg_in),
    .digit_o    (lut_digit),
    .is_legal_o (lut_legal),
    .is_blank_o (lut_blank)
  );

  always_comb begin
    // cnt_q == 0 only after reset: the first sample always opens a run, even if
    // it happens to match the reset value of seg_q.
    new_run = (cnt_q == '0) || (seg_in != seg_q);

    if (new_run) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // A held pattern in LOCKED keeps cnt saturated but must not re-fire; a new
    // run may lock immediately when STABLE_CYCLES is 1.
    lock = (cnt_d == CNT_MAX) && (new_run || (state_q == TRACK));

    if (lock) begin
      state_d = LOCKED;
    end else if (new_run) begin
      state_d = TRACK;
    end else begin
      state_d = state_q;
    end

    valid_d = lock;
    digit_d = digit_q;
    blank_d = blank_q;
    err_d   = err_q;
    if (lock) begin
      if (lut_legal) begin
        digit_d = lut_digit;
        blank_d = 1'b0;
        err_d   = 1'b0;
      end else if (lut_blank) begin
        blank_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        blank_d = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= SEG_BLANK;
      cnt_q   <= '0;
      state_q <= TRACK;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      err_q   <= err_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sevenseg_decoder.sv
// tb_sevenseg_decoder: directed test-plan steps plus randomized traffic on two
// decoders (STABLE_CYCLES=4 and =1), checked every cycle against a run-length
// reference model. Outputs are packed as {digit_valid, digit, blank, err}.
module tb_sevenseg_decoder;

`ifdef SEVENSEG_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam logic [6:0] CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam int S_CYC [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg4, seg1;
  logic [3:0] digit4, digit1;
  logic       vld4, vld1, blank4, blank1, err4, err1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sevenseg_decoder #(.STABLE_CYCLES(4)) dut4 (
    .clk (clk), .reset (reset), .seg_in (seg4),
    .digit (digit4), .digit_valid (vld4), .blank (blank4), .err (err4)
  );

  sevenseg_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk (clk), .reset (reset), .seg_in (seg1),
    .digit (digit1), .digit_valid (vld1), .blank (blank1), .err (err1)
  );

  wire [6:0] obs4 = {vld4, digit4, blank4, err4};
  wire [6:0] obs1 = {vld1, digit1, blank1, err1};

  // Reference model: length of the current run of identical samples; a pulse
  // fires exactly when the run length equals the stability requirement.
  int         m_last [2];
  int         m_run  [2];
  logic [6:0] m_out  [2];

  function automatic logic [6:0] lock_out(input logic [6:0] s, input logic [6:0] prev);
    for (int k = 0; k < 16; k++) begin
      if (s == CODES[k] && (k < 10 || HEX_EN)) return {1'b1, 4'(k), 2'b00};
    end
    if (s == 7'b1111111) return {1'b1, prev[5:2], 2'b10};
    return {1'b1, prev[5:2], 2'b01};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_last[i] = -1;
        m_run[i]  = 0;
        m_out[i]  = 7'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [6:0] s;
        s = (i == 0) ? seg4 : seg1;
        if (m_last[i] != int'(s)) m_run[i] = 1;
        else m_run[i] = m_run[i] + 1;
        m_last[i] = int'(s);
        if (m_run[i] == S_CYC[i]) m_out[i] = lock_out(s, m_out[i]);
        else m_out[i][6] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one sample per DUT, let one rising edge take it, check at the falling edge.
  task automatic tick(input logic [6:0] a, input logic [6:0] b);
    seg4 = a;
    seg1 = b;
    @(posedge clk);
    @(negedge clk);
    check("model4", obs4, m_out[0]);
    check("model1", obs1, m_out[1]);
  endtask

  function automatic logic [6:0] pick(input logic [6:0] prev);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return prev;
    if (r == 6) return 7'b1111111;
    if (r == 7) return 7'($urandom);
    return CODES[$urandom_range(0, 15)];
  endfunction

  initial begin
    logic [6:0] exp_f;
    logic [6:0] r4, r1;

    reset = 1'b1;
    seg4  = 7'b1111001;
    seg1  = 7'b1111111;
    @(negedge clk);
    @(negedge clk);
    check("reset4", obs4, 7'd0);
    check("reset1", obs1, 7'd0);
    reset = 1'b0;

    // Held digit 1 locks after the 4th post-reset edge, then stays quiet.
    repeat (3) tick(7'b1111001, 7'b1111111);
    check("pre_lock1", obs4, 7'b0_0000_00);
    tick(7'b1111001, 7'b1111111);
    check("lock1", obs4, 7'b1_0001_00);
    repeat (3) tick(7'b1111001, 7'b1111111);
    check("held1", obs4, 7'b0_0001_00);

    // 3-edge glitch on 2 is filtered; return to 1 needs a fresh run.
    repeat (3) tick(7'b0100100, 7'b1111111);
    check("glitch", obs4, 7'b0_0001_00);
    repeat (3) tick(7'b1111001, 7'b1111111);
    check("return_pre", obs4, 7'b0_0001_00);
    tick(7'b1111001, 7'b1111111);
    check("return_lock", obs4, 7'b1_0001_00);

    // 9, then blank and an illegal pattern keep the digit.
    repeat (4) tick(7'b0010000, 7'b1111111);
    check("lock9", obs4, 7'b1_1001_00);
    repeat (4) tick(7'b1111111, 7'b1111111);
    check("lock_blank", obs4, 7'b1_1001_10);
    repeat (4) tick(7'b1010101, 7'b1111111);
    check("lock_err", obs4, 7'b1_1001_01);

    exp_f = HEX_EN ? 7'b1_1111_00 : 7'b1_1001_01;
    repeat (4) tick(7'b0001110, 7'b1111111);
    check("lock_hexF", obs4, exp_f);

    // Reset lands on the edge that would complete a run of 8.
    repeat (3) tick(7'b0000000, 7'b1111111);
    seg4  = 7'b0000000;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid4", obs4, 7'd0);
    check("reset_mid1", obs1, 7'd0);
    reset = 1'b0;
    repeat (3) tick(7'b0000000, 7'b1111111);
    check("post_reset_pre", obs4, 7'd0);
    tick(7'b0000000, 7'b1111111);
    check("post_reset_lock8", obs4, 7'b1_1000_00);

    // Single-cycle lock: every change pulses, digit follows one cycle late.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 10; k++) begin
        tick(7'b1111001, CODES[k]);
        check("walk1", obs1, {1'b1, 4'(k), 2'b00});
      end
    end

    // Randomized traffic, biased toward holding so the 4-cycle DUT locks often.
    r4 = seg4;
    r1 = seg1;
    for (int n = 0; n < 400; n++) begin
      r4 = pick(r4);
      r1 = pick(r1);
      tick(r4, r1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_decoder.md
Name: sevenseg_decoder

Overview:
- Inverse of the team's seven-segment encoder: watches an active-low 7-bit segment bus (bit 0 = segment a … bit 6 = segment g) and recovers the BCD digit it shows.
- Filters glitches: a pattern is accepted only after it has been stable for a programmable number of clocks.
- Used in ModelSim benches and on-chip self-check to confirm HEX display drive without a human reading LEDs.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern locks (legal range 1..255).
- CNT_W, $clog2(STABLE_CYCLES+1), localparam width of the stability counter; not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  active-low segment pattern under observation.
- digit  output  4  last locked valid digit.
- digit_valid  output  1  one-cycle pulse when a pattern locks (valid digit, blank, or invalid).
- blank  output  1  level; last locked pattern was all-off (7'b1111111).
- err  output  1  level; last locked pattern was not a legal code.

Behaviour:
- Reset, asserted asynchronously:
  - digit=0, digit_valid=0, blank=0, err=0.
  - Internal seg_q=7'b1111111, cnt=0, state=TRACK.
- Sampling: seg_q <= seg_in every edge. An edge where seg_in != seg_q starts a new run with cnt=1. An edge where seg_in == seg_q increments cnt, saturating at STABLE_CYCLES.
- Reset state counts as no run. The first edge after reset release counts as sample 1, whatever the value of seg_in.
- States:
  - TRACK: counting. When the edge makes cnt reach STABLE_CYCLES, the block moves to LOCKED and updates outputs at that same edge.
  - LOCKED: holds outputs. Any seg_in change moves it back to TRACK with cnt=1.
- Latency: a pattern P sampled at edges t0..t0+STABLE_CYCLES-1 produces digit_valid high in the cycle after edge t0+STABLE_CYCLES-1, for exactly one cycle. With STABLE_CYCLES=1, every change locks at its first edge.
- Only one pulse per stable run; a held pattern never re-pulses. A run that ends before reaching STABLE_CYCLES produces nothing, and the outputs keep their previous values.
- On lock:
  - Legal code 0-9: digit=value, blank=0, err=0.
  - 1111111: blank=1, err=0, digit unchanged.
  - Any other code: err=1, blank=0, digit unchanged.
- Legal codes (seg_in[6:0] for 0-9): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Reset mid-run discards the partial count. Reset coincident with a lock edge wins: no pulse.

Optional Feature:
- Macro SEVENSEG_HEX_EN.
- When defined, six extra codes lock as legal with err=0:
  - 0001000 → A (4'hA)
  - 0000011 → b (4'hB)
  - 1000110 → C (4'hC)
  - 0100001 → d (4'hD)
  - 0000110 → E (4'hE)
  - 0001110 → F (4'hF)
- When undefined, those six codes lock with err=1.

Decomposition:
- Package sevenseg_pkg:
  - SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK pattern constants.
  - Typedef seg_t (logic [6:0]).
  - Typedef dec_state_t (TRACK, LOCKED).
- Sub-module sevenseg_lut: combinational pattern → {digit, is_legal, is_blank}, with the SEVENSEG_HEX_EN switch inside it. The top level holds seg_q, cnt, the FSM and output registers.

Test Plan:
- Reset with seg_in=1111001 held, STABLE_CYCLES=4 → digit_valid single pulse after the 4th post-reset edge, digit=1, blank=0, err=0; no further pulses while held.
- 1111001 locked, then 0100100 held for 3 edges, then back to 1111001 → no pulse during the glitch. After the return, a fresh run of 4 edges gives another pulse with digit=1.
- Lock 0010000 (digit=9), then lock 1111111 → pulse, blank=1, digit stays 9. Then lock 1010101 → pulse, err=1, blank=0, digit stays 9.
- Drive 0001110 for 4 edges → with SEVENSEG_HEX_EN: digit=4'hF, err=0. Without it: err=1, digit unchanged.
- Assert reset on the edge where cnt would reach 4 on pattern 0000000 → no pulse; all outputs 0. After release, 4 more edges of 0000000 give a pulse with digit=8.
- STABLE_CYCLES=1, seg_in changes every edge through 0-9 → one pulse per edge, with digit tracking seg_in one cycle late.
